// File: rtl/dart_rx_port.sv
// DART serial receive port: 8N1 deframer, byte-to-word assembler
// and show-ahead word FIFO drained with a valid/ack handshake.
module dart_rx_port #(
  parameter int WIDTH      = 16,
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_FREQ = 50000000,
  parameter int LOG_DEP    = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               RS232_RX_DATA,
  output logic [WIDTH-1:0]   rx_data,
  output logic               rx_valid,
  input  logic               rx_ack,
  output logic               rx_busy,
  output logic               frame_error,
  output logic               overflow_error,
  output logic [LOG_DEP:0]   fifo_count
);

  localparam int D     = CLOCK_FREQ / BAUD_RATE;
  localparam int TW    = $clog2(D + 1);
  localparam int N     = (WIDTH + 7) >> 3;
  localparam int IW    = (N > 1) ? $clog2(N) : 1;
  localparam int AW    = 8 * N;
  localparam int DEPTH = 1 << LOG_DEP;

  localparam logic [TW-1:0] T_HALF = TW'(D / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(D - 1);
  localparam logic [IW-1:0] I_LAST = IW'(N - 1);
  localparam logic [LOG_DEP:0] C_FULL = (LOG_DEP + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT
  } state_t;

  // line synchronizer
  logic [1:0] sync_q, sync_d;
  logic       line_s;

  // deframer
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          bv_q, bv_d;
  logic          fe_q, fe_d;

  // assembler
  logic [AW-1:0] asm_q, asm_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [AW-1:0] merged;
  logic          push;
  logic [WIDTH-1:0] push_word;

  // fifo
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [WIDTH-1:0]   mem_d [DEPTH];
  logic [LOG_DEP-1:0] wr_q, wr_d;
  logic [LOG_DEP-1:0] rd_q, rd_d;
  logic [LOG_DEP:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               pop, full, wr_en;

  assign sync_d = {sync_q[0], RS232_RX_DATA};
  assign line_s = sync_q[1];

  // bit timing and frame state; a low enable parks everything in idle
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    bv_d    = 1'b0;
    fe_d    = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
      timer_d = '0;
      bit_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!line_s) begin
            timer_d = T_HALF;
            state_d = S_START;
          end
        end
        S_START: begin
          if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
          end else if (line_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            timer_d = T_FULL;
            bit_d   = '0;
          end
        end
        S_DATA: begin
          if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
          end else begin
            shift_d = {line_s, shift_q[7:1]};
            timer_d = T_FULL;
            if (bit_q == 3'd7) begin
              state_d = S_STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
          end else if (line_s) begin
            bv_d    = 1'b1;
            state_d = S_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (line_s) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // drop the received byte into its lane; the last lane completes a word
  always_comb begin
    merged    = asm_q;
    asm_d     = asm_q;
    idx_d     = idx_q;
    push      = 1'b0;
    push_word = '0;
    for (int k = 0; k < N; k++) begin
      if (IW'(k) == idx_q) begin
        merged[8*k +: 8] = shift_q;
      end
    end
    if (!enable) begin
      idx_d = '0;
    end else if (bv_q) begin
      if (idx_q == I_LAST) begin
        push      = 1'b1;
        push_word = merged[WIDTH-1:0];
        idx_d     = '0;
      end else begin
        asm_d = merged;
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // show-ahead fifo; a full fifo still accepts a push when a pop frees a slot
  always_comb begin
    pop   = rx_ack & (count_q != '0);
    full  = (count_q == C_FULL);
    wr_en = push & (~full | pop);
    ovf_d = ovf_q | (push & full & ~pop);
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    count_d = count_q;
    if (wr_en) begin
      mem_d[wr_q] = push_word;
      wr_d = wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = rd_q + 1'b1;
    end
    if (wr_en && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!wr_en && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q  <= 2'b11;
      state_q <= S_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      bv_q    <= 1'b0;
      fe_q    <= 1'b0;
      asm_q   <= '0;
      idx_q   <= '0;
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      bv_q    <= bv_d;
      fe_q    <= fe_d;
      asm_q   <= asm_d;
      idx_q   <= idx_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign rx_valid       = (count_q != '0);
  assign rx_data        = rx_valid ? mem_q[rd_q] : '0;
  assign rx_busy        = (state_q != S_IDLE);
  assign frame_error    = fe_q;
  assign overflow_error = ovf_q;
  assign fifo_count     = count_q;

endmodule

// File: tb/tb_dart_rx_port.sv
// Scoreboard bench for dart_rx_port: serial frames in, words
// checked against a queue of expected words on each pop.
module tb_dart_rx_port;

  localparam int D = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        line;
  logic        rx_ack;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_busy;
  logic        frame_error;
  logic        overflow_error;
  logic [2:0]  fifo_count;

  int checks = 0;
  int failures = 0;
  int fe_cycles = 0;
  bit busy_seen = 0;
  logic [15:0] exp_q[$];
  bit exp_ovf = 0;

  always #5 clock = ~clock;

  dart_rx_port #(
    .WIDTH(16),
    .BAUD_RATE(9600),
    .CLOCK_FREQ(153600),
    .LOG_DEP(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .RS232_RX_DATA(line),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ack(rx_ack),
    .rx_busy(rx_busy),
    .frame_error(frame_error),
    .overflow_error(overflow_error),
    .fifo_count(fifo_count)
  );

  always @(negedge clock) begin
    if (frame_error) fe_cycles++;
    if (rx_busy) busy_seen = 1;
  end

  initial begin
    #600000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop,
                           input int ack_at, output int rise_at,
                           output logic [15:0] ack_data);
    logic [9:0] fr;
    logic prev;
    fr = {stop, b, 1'b0};
    rise_at = -1;
    ack_data = '0;
    prev = rx_valid;
    for (int j = 0; j < 10 * D; j++) begin
      @(negedge clock);
      if (rx_valid && !prev && rise_at < 0) rise_at = j;
      prev = rx_valid;
      if (j == ack_at) begin
        ack_data = rx_data;
        rx_ack = 1'b1;
      end else begin
        rx_ack = 1'b0;
      end
      line = fr[j/D];
    end
  endtask

  task automatic send_partial(input logic [7:0] b, input int cyc);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int j = 0; j < cyc; j++) begin
      @(negedge clock);
      line = fr[j/D];
    end
  endtask

  task automatic send_word(input logic [15:0] w, output int rise);
    int r0;
    logic [15:0] ad;
    if (exp_q.size() < 4) exp_q.push_back(w);
    else exp_ovf = 1;
    send_byte(w[7:0], 1'b1, -1, r0, ad);
    send_byte(w[15:8], 1'b1, -1, rise, ad);
  endtask

  task automatic do_pop(output logic v, output logic [15:0] d);
    @(negedge clock);
    v = rx_valid;
    d = rx_data;
    rx_ack = 1'b1;
    @(negedge clock);
    rx_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    line = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    exp_ovf = 0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_ack = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (rx_data !== 16'h0) begin
      failures++;
      $display("FAIL reset_data got=%h want=0000", rx_data);
    end
    checks++;
    if (rx_valid !== 1'b0 || rx_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b%b want=00", rx_valid, rx_busy);
    end
    checks++;
    if (frame_error !== 1'b0 || overflow_error !== 1'b0) begin
      failures++;
      $display("FAIL reset_err got=%b%b want=00", frame_error, overflow_error);
    end
    checks++;
    if (fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL reset_count got=%0d want=0", fifo_count);
    end
    reset = 1'b0;
    rx_ack = 1'b0;
    exp_q.delete();
    exp_ovf = 0;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_basic();
    int rise;
    logic v;
    logic [15:0] d, want;
    send_word(16'h1234, rise);
    checks++;
    if (rise !== 156) begin
      failures++;
      $display("FAIL basic_latency got=%0d want=156", rise);
    end
    checks++;
    if (fifo_count !== 3'd1) begin
      failures++;
      $display("FAIL basic_count got=%0d want=1", fifo_count);
    end
    do_pop(v, d);
    want = exp_q.pop_front();
    checks++;
    if (v !== 1'b1 || d !== want) begin
      failures++;
      $display("FAIL basic_word got=%b/%h want=1/%h", v, d, want);
    end
    checks++;
    if (rx_valid !== 1'b0 || rx_data !== 16'h0 || fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL basic_empty got=%b/%h/%0d want=0/0000/0",
               rx_valid, rx_data, fifo_count);
    end
  endtask

  task automatic test_glitch();
    int fe0, rise;
    logic v;
    logic [15:0] d, want;
    fe0 = fe_cycles;
    @(negedge clock);
    busy_seen = 0;
    line = 1'b0;
    repeat (5) @(negedge clock);
    line = 1'b1;
    repeat (3 * D) @(negedge clock);
    checks++;
    if (busy_seen !== 1'b1 || rx_busy !== 1'b0) begin
      failures++;
      $display("FAIL glitch_busy got=%b/%b want=1/0", busy_seen, rx_busy);
    end
    checks++;
    if (fe_cycles != fe0 || fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL glitch_quiet got=%0d/%0d want=0/0",
               fe_cycles - fe0, fifo_count);
    end
    send_word(16'hABCD, rise);
    do_pop(v, d);
    want = exp_q.pop_front();
    checks++;
    if (v !== 1'b1 || d !== want) begin
      failures++;
      $display("FAIL glitch_word got=%b/%h want=1/%h", v, d, want);
    end
  endtask

  task automatic test_framing();
    int fe0, r;
    logic v;
    logic [15:0] d, want, ad;
    fe0 = fe_cycles;
    send_byte(8'h55, 1'b0, -1, r, ad);
    repeat (40) @(negedge clock);
    checks++;
    if (rx_busy !== 1'b1) begin
      failures++;
      $display("FAIL frame_busy got=%b want=1", rx_busy);
    end
    line = 1'b1;
    repeat (D) @(negedge clock);
    checks++;
    if (fe_cycles - fe0 != 1) begin
      failures++;
      $display("FAIL frame_pulse got=%0d want=1", fe_cycles - fe0);
    end
    checks++;
    if (rx_busy !== 1'b0 || fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL frame_idle got=%b/%0d want=0/0", rx_busy, fifo_count);
    end
    send_word(16'h1234, r);
    do_pop(v, d);
    want = exp_q.pop_front();
    checks++;
    if (v !== 1'b1 || d !== want) begin
      failures++;
      $display("FAIL frame_word got=%b/%h want=1/%h", v, d, want);
    end
  endtask

  task automatic test_overflow();
    int r;
    logic v;
    logic [15:0] d, want;
    for (int i = 1; i <= 5; i++) send_word(16'(i), r);
    checks++;
    if (fifo_count !== 3'(exp_q.size())) begin
      failures++;
      $display("FAIL ovf_count got=%0d want=%0d", fifo_count, exp_q.size());
    end
    checks++;
    if (overflow_error !== exp_ovf) begin
      failures++;
      $display("FAIL ovf_flag got=%b want=%b", overflow_error, exp_ovf);
    end
    while (exp_q.size() > 0) begin
      do_pop(v, d);
      want = exp_q.pop_front();
      checks++;
      if (v !== 1'b1 || d !== want) begin
        failures++;
        $display("FAIL ovf_pop got=%b/%h want=1/%h", v, d, want);
      end
    end
    checks++;
    if (rx_valid !== 1'b0 || fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL ovf_drain got=%b/%0d want=0/0", rx_valid, fifo_count);
    end
  endtask

  task automatic test_full_pop();
    int r;
    logic v;
    logic [15:0] d, want, ad;
    do_reset();
    for (int i = 1; i <= 4; i++) send_word(16'(i), r);
    send_byte(8'h05, 1'b1, -1, r, ad);
    send_byte(8'h00, 1'b1, 155, r, ad);
    want = exp_q.pop_front();
    exp_q.push_back(16'h0005);
    checks++;
    if (ad !== want) begin
      failures++;
      $display("FAIL full_ackhead got=%h want=%h", ad, want);
    end
    checks++;
    if (overflow_error !== 1'b0 || fifo_count !== 3'd4) begin
      failures++;
      $display("FAIL full_state got=%b/%0d want=0/4",
               overflow_error, fifo_count);
    end
    while (exp_q.size() > 0) begin
      do_pop(v, d);
      want = exp_q.pop_front();
      checks++;
      if (v !== 1'b1 || d !== want) begin
        failures++;
        $display("FAIL full_pop got=%b/%h want=1/%h", v, d, want);
      end
    end
  endtask

  task automatic test_reset_abort();
    int r;
    logic v;
    logic [15:0] d, want;
    send_word(16'h1111, r);
    send_partial(8'h3C, 4 * D);
    reset = 1'b1;
    line = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (rx_data !== 16'h0 || rx_valid !== 1'b0 || rx_busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_abort_out got=%h/%b/%b want=0000/0/0",
               rx_data, rx_valid, rx_busy);
    end
    checks++;
    if (fifo_count !== 3'd0 || frame_error !== 1'b0 ||
        overflow_error !== 1'b0) begin
      failures++;
      $display("FAIL rst_abort_state got=%0d/%b/%b want=0/0/0",
               fifo_count, frame_error, overflow_error);
    end
    reset = 1'b0;
    exp_q.delete();
    exp_ovf = 0;
    repeat (D) @(negedge clock);
    send_word(16'h5678, r);
    do_pop(v, d);
    want = exp_q.pop_front();
    checks++;
    if (v !== 1'b1 || d !== want) begin
      failures++;
      $display("FAIL rst_abort_word got=%b/%h want=1/%h", v, d, want);
    end
  endtask

  task automatic test_enable_abort();
    int r, fe0;
    logic v;
    logic [15:0] d, want, ad;
    fe0 = fe_cycles;
    send_byte(8'h34, 1'b1, -1, r, ad);
    send_partial(8'hA5, 5 * D);
    @(negedge clock);
    enable = 1'b0;
    line = 1'b1;
    @(negedge clock);
    enable = 1'b1;
    repeat (3 * D) @(negedge clock);
    checks++;
    if (rx_busy !== 1'b0 || fe_cycles != fe0 || fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL en_abort_quiet got=%b/%0d/%0d want=0/0/0",
               rx_busy, fe_cycles - fe0, fifo_count);
    end
    send_word(16'hBEEF, r);
    do_pop(v, d);
    want = exp_q.pop_front();
    checks++;
    if (v !== 1'b1 || d !== want) begin
      failures++;
      $display("FAIL en_abort_word got=%b/%h want=1/%h", v, d, want);
    end
    checks++;
    if (fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL en_abort_count got=%0d want=0", fifo_count);
    end
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    line = 1'b1;
    rx_ack = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_overflow();
    test_full_pop();
    test_reset_abort();
    test_enable_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
